uart_rec_ctrl: RTL and testbench

Receive-side sequencer for the UART link. It waits for recSig, times the 3-bit-period lead-in, then paces bit sampling of bsIn with an internal bit-period counter. It loads a packetSize shift register through its regShift/regLD controls and presents the assembled word to a consumer with a valid/ack handshake. It replaces the ClockDiv + RecFSM pair: everything runs on the single system clock, with no derived clock.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_rec_shiftreg.sv | 27 ++
 rtl/uart_rec_ctrl.sv | 141 ++++++++++++++
 tb/tb_uart_rec_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive sequencer.
package uart_pkg;

  typedef enum logic [1:0] {
    SH_HOLD = 2'b00,
    SH_IN   = 2'b01,
    SH_CLR  = 2'b11
  } reg_shift_t;

  typedef enum logic [1:0] {
    IDLE,
    LEAD,
    SHIFT,
    HOLD
  } rec_state_t;

  localparam int unsigned LEAD_PERIODS = 3;

endpackage

// File: rtl/uart_rec_shiftreg.sv
// packetSize-wide receive shift register; MSB-first, new bits enter at bit 0.
module uart_rec_shiftreg
  import uart_pkg::*;
#(
  parameter int unsigned packetSize = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  regLD,
  input  logic [1:0]            regShift,
  input  logic                  bsIn,
  output logic [packetSize-1:0] data
);

  always_ff @(posedge clk) begin
    if (rst || regLD) begin
      data <= '0;
    end else begin
      case (reg_shift_t'(regShift))
        SH_IN:   data <= {data[packetSize-2:0], bsIn};
        SH_CLR:  data <= '0;
        default: data <= data;
      endcase
    end
  end

endmodule

// File: rtl/uart_rec_ctrl.sv
// UART receive sequencer: lead-in timing, mid-bit sampling and valid/ack hand-off.
// Optional trailing even-parity bit enabled by defining UART_REC_PARITY_EN.
module uart_rec_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned packetSize = 16,
  parameter int unsigned cycleDiv   = 100
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bsIn,
  input  logic                  recSig,
  input  logic                  dataAck,
  output logic [packetSize-1:0] data,
  output logic                  dataValid,
  output logic                  busy,
  output logic                  overrun,
  output logic                  parityErr
);

  localparam int unsigned SP = cycleDiv / 2;
`ifdef UART_REC_PARITY_EN
  localparam int unsigned FRAME_BITS = packetSize + 1;
`else
  localparam int unsigned FRAME_BITS = packetSize;
`endif
  localparam int unsigned CNT_W = (cycleDiv > 1) ? $clog2(cycleDiv) : 1;
  localparam int unsigned IDX_W = $clog2(FRAME_BITS + LEAD_PERIODS);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(cycleDiv - 1);
  localparam logic [CNT_W-1:0] CNT_SP   = CNT_W'(SP);
  localparam logic [IDX_W-1:0] LEAD_END = IDX_W'(LEAD_PERIODS - 1);
  localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(FRAME_BITS - 1);
  localparam logic [IDX_W-1:0] DATA_END = IDX_W'(packetSize);

  rec_state_t       state, next_state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] bit_idx;
  logic             cnt_wrap, at_sp;
  logic             reg_ld;
  reg_shift_t       reg_shift;

  assign cnt_wrap = (cnt == CNT_MAX);
  assign at_sp    = (cnt == CNT_SP);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // In LEAD, bit_idx counts completed bit periods; in SHIFT it counts samples.
  always_comb begin
    next_state = state;
    reg_ld     = 1'b0;
    reg_shift  = SH_HOLD;
    case (state)
      IDLE: begin
        if (recSig) begin
          next_state = LEAD;
          reg_ld     = 1'b1;
        end
      end
      LEAD: begin
        if (cnt_wrap && bit_idx == LEAD_END) next_state = SHIFT;
      end
      SHIFT: begin
        if (at_sp) begin
          if (bit_idx < DATA_END) reg_shift = SH_IN;
          if (bit_idx == LAST_BIT) next_state = HOLD;
        end
      end
      HOLD: begin
        if (dataAck) begin
          if (recSig) begin
            next_state = LEAD;
            reg_ld     = 1'b1;
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      bit_idx <= '0;
    end else if (next_state != state) begin
      cnt     <= '0;
      bit_idx <= '0;
    end else if (state == LEAD || state == SHIFT) begin
      cnt <= cnt_wrap ? '0 : cnt + 1'b1;
      if ((state == LEAD && cnt_wrap) || (state == SHIFT && at_sp))
        bit_idx <= bit_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy      <= 1'b0;
      dataValid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      busy      <= (next_state == LEAD) || (next_state == SHIFT);
      dataValid <= (next_state == HOLD);
      if (state == HOLD) begin
        if (dataAck)     overrun <= 1'b0;
        else if (recSig) overrun <= 1'b1;
      end
    end
  end

`ifdef UART_REC_PARITY_EN
  // Parity bit is consumed on the sample after the last data bit and never enters data.
  always_ff @(posedge clk) begin
    if (rst) begin
      parityErr <= 1'b0;
    end else if (state == SHIFT && at_sp && bit_idx == DATA_END) begin
      parityErr <= (^data) ^ bsIn;
    end else if (state == HOLD && dataAck) begin
      parityErr <= 1'b0;
    end
  end
`else
  assign parityErr = 1'b0;
`endif

  uart_rec_shiftreg #(
    .packetSize(packetSize)
  ) u_shiftreg (
    .clk      (clk),
    .rst      (rst),
    .regLD    (reg_ld),
    .regShift (reg_shift),
    .bsIn     (bsIn),
    .data     (data)
  );

endmodule

// File: tb/tb_uart_rec_ctrl.sv
// Scoreboard bench for uart_rec_ctrl (packetSize=8, cycleDiv=4).
module tb_uart_rec_ctrl;

  localparam int unsigned PS = 8;
  localparam int unsigned CD = 4;
`ifdef UART_REC_PARITY_EN
  localparam int unsigned FB  = PS + 1;
  localparam logic        PAR = 1'b1;
`else
  localparam int unsigned FB  = PS;
  localparam logic        PAR = 1'b0;
`endif
  localparam int LAT = 3 * CD + CD / 2 + 1 + (FB - 1) * CD;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          bsIn = 1'b0;
  logic          recSig = 1'b0;
  logic          dataAck = 1'b0;
  logic [PS-1:0] data;
  logic          dataValid, busy, overrun, parityErr;

  typedef struct packed {
    logic [PS-1:0] word;
    logic          perr;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   t0 = 0;
  logic prev_valid = 1'b0;

  uart_rec_ctrl #(.packetSize(PS), .cycleDiv(CD)) dut (
    .clk       (clk),
    .rst       (rst),
    .bsIn      (bsIn),
    .recSig    (recSig),
    .dataAck   (dataAck),
    .data      (data),
    .dataValid (dataValid),
    .busy      (busy),
    .overrun   (overrun),
    .parityErr (parityErr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare each newly presented word with the scoreboard head.
  always @(negedge clk) begin
    if (!rst && dataValid && !prev_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", 32'(data), 32'hDEAD);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_data", 32'(data), 32'(e.word));
        chk("sb_parity", 32'(parityErr), 32'(e.perr));
        chk("sb_latency", 32'(cyc - t0), 32'(LAT));
        chk("sb_busy_low", 32'(busy), 32'd0);
      end
    end
    prev_valid <= dataValid;
  end

  task automatic start_frame(input logic b2b);
    recSig  = 1'b1;
    dataAck = b2b;
    @(posedge clk); #1;
    t0      = cyc;
    recSig  = 1'b0;
    dataAck = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("valid_after_start", 32'(dataValid), 32'd0);
    chk("overrun_after_start", 32'(overrun), 32'd0);
    repeat (3 * CD) @(posedge clk);
  endtask

  task automatic send_frame(input logic [PS-1:0] word, input logic pbit,
                            input logic exp_perr, input logic b2b);
    exp_t e;
    e.word = word;
    e.perr = exp_perr;
    sb.push_back(e);
    start_frame(b2b);
    for (int k = 0; k < int'(FB); k++) begin
      #1 bsIn = (k < int'(PS)) ? word[PS-1-k] : pbit;
      repeat (CD) @(posedge clk);
    end
    #1;
    chk("valid_after_frame", 32'(dataValid), 32'd1);
  endtask

  task automatic ack_word;
    dataAck = 1'b1;
    @(posedge clk); #1;
    dataAck = 1'b0;
    chk("ack_valid_low", 32'(dataValid), 32'd0);
    chk("ack_overrun_low", 32'(overrun), 32'd0);
    chk("ack_parity_low", 32'(parityErr), 32'd0);
    chk("ack_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_data", 32'(data), 32'd0);
    chk("rst_valid", 32'(dataValid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_parity", 32'(parityErr), 32'd0);
    @(posedge clk); #1;

    // A3 has four ones: parity bit 1 is wrong, so parityErr when parity is enabled.
    send_frame(8'hA3, 1'b1, PAR, 1'b0);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      chk("hold_data", 32'(data), 32'hA3);
      chk("hold_valid", 32'(dataValid), 32'd1);
    end

    recSig = 1'b1;
    @(posedge clk); #1;
    recSig = 1'b0;
    chk("ovr_flag", 32'(overrun), 32'd1);
    chk("ovr_data", 32'(data), 32'hA3);
    chk("ovr_valid", 32'(dataValid), 32'd1);
    chk("ovr_busy", 32'(busy), 32'd0);
    repeat (2 * CD) @(posedge clk);
    #1 chk("ovr_sticky", 32'(overrun), 32'd1);
    ack_word();
    repeat (3) @(posedge clk);
    #1 chk("idle_no_valid", 32'(dataValid), 32'd0);

    send_frame(8'hA3, 1'b0, 1'b0, 1'b0);
    // recSig with dataAck on the same edge: ack taken, next frame starts at once.
    send_frame(8'h5C, 1'b0, 1'b0, 1'b1);
    ack_word();

    // Abort after three captured bits.
    start_frame(1'b0);
    for (int k = 0; k < 3; k++) begin
      #1 bsIn = 1'b1;
      repeat (CD) @(posedge clk);
    end
    #1 chk("pre_abort_data", 32'(data), 32'h7);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_data", 32'(data), 32'd0);
    chk("abort_valid", 32'(dataValid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_overrun", 32'(overrun), 32'd0);
    chk("abort_parity", 32'(parityErr), 32'd0);
    @(posedge clk); #1;

    send_frame(8'hFF, 1'b0, 1'b0, 1'b0);
    ack_word();
    repeat (4) @(posedge clk);
    #1 chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
